// File: rtl/rv_ibus_bridge.sv
// +--------------------------------------------------------------------------+
// | Module   : rv_ibus_bridge                                                |
// | Purpose  : instruction-fetch bridge, one-word line buffer to Wishbone B4 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module rv_ibus_bridge #(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_cyc,
  input  logic [IADDR_SPACE_BITS-1:0] i_addr,
  input  logic                        i_inv,
  output logic                        o_ack,
  output logic [31:0]                 o_instruction,
  output logic                        o_fault,
  output logic                        o_wb_cyc,
  output logic                        o_wb_stb,
  output logic [IADDR_SPACE_BITS-3:0] o_wb_adr,
  input  logic [31:0]                 i_wb_dat,
  input  logic                        i_wb_ack,
  input  logic                        i_wb_err,
  output logic                        o_busy
);

  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_buf_valid;
  logic [IADDR_SPACE_BITS-3:0] r_buf_tag;
  logic [31:0]                 r_buf_data;
  logic                        r_buf_fault;
  logic                        r_inv_pend;
  logic [7:0]                  r_cnt;
  logic                        r_wb_cyc;
  logic [IADDR_SPACE_BITS-3:0] r_wb_adr;
  logic [31:0]                 r_instruction;
  logic                        r_fault;

  logic w_hit;
  logic w_start;
  logic w_done;
  logic w_fault_fill;
  logic w_unused_addr_bits;

  assign w_unused_addr_bits = ^i_addr[1:0];
  assign w_hit        = r_buf_valid && (r_buf_tag == i_addr[IADDR_SPACE_BITS-1:2]);
  assign o_ack        = (r_state == S_IDLE) && i_cyc && w_hit && !i_inv;
  // Anything other than a clean ack (error, or timeout) fills a faulting zero word.
  assign w_fault_fill = i_wb_err || !i_wb_ack;

  assign o_busy        = (r_state == S_REQ);
  assign o_wb_cyc      = r_wb_cyc;
  assign o_wb_stb      = r_wb_cyc;
  assign o_wb_adr      = r_wb_adr;
  assign o_instruction = r_instruction;
  assign o_fault       = r_fault;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cyc && !w_hit && !i_inv) begin
          w_start     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (i_wb_err || i_wb_ack || (r_cnt == C_TMO_LAST)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_buf_valid   <= 1'b0;
      r_buf_tag     <= '0;
      r_buf_data    <= '0;
      r_buf_fault   <= 1'b0;
      r_inv_pend    <= 1'b0;
      r_cnt         <= '0;
      r_wb_cyc      <= 1'b0;
      r_wb_adr      <= '0;
      r_instruction <= '0;
      r_fault       <= 1'b0;
    end else begin
      if (o_ack) begin
        r_instruction <= r_buf_data;
        r_fault       <= r_buf_fault;
      end
      if (r_state == S_IDLE) begin
        if (i_inv) begin
          r_buf_valid <= 1'b0;
        end
        if (w_start) begin
          r_wb_adr <= i_addr[IADDR_SPACE_BITS-1:2];
          r_wb_cyc <= 1'b1;
          r_cnt    <= '0;
        end
      end else if (w_done) begin
        r_buf_tag   <= r_wb_adr;
        r_buf_data  <= w_fault_fill ? 32'h0000_0000 : i_wb_dat;
        r_buf_fault <= w_fault_fill;
        // An invalidate seen at any point of the transaction keeps the fill unusable.
        r_buf_valid <= !(r_inv_pend || i_inv);
        r_inv_pend  <= 1'b0;
        r_wb_cyc    <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
        if (i_inv) begin
          r_inv_pend <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_ibus_bridge.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_rv_ibus_bridge                                             |
// | Purpose  : self-checking bench for rv_ibus_bridge with a Wishbone slave  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_rv_ibus_bridge;

  localparam int AW  = 16;
  localparam int TMO = 4;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b1;
  logic          i_cyc = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_inv = 1'b0;
  logic          o_ack;
  logic [31:0]   o_instruction;
  logic          o_fault;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic [AW-3:0] o_wb_adr;
  logic [31:0]   i_wb_dat = '0;
  logic          i_wb_ack = 1'b0;
  logic          i_wb_err = 1'b0;
  logic          o_busy;

  rv_ibus_bridge #(
    .IADDR_SPACE_BITS(AW),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_cyc        (i_cyc),
    .i_addr       (i_addr),
    .i_inv        (i_inv),
    .o_ack        (o_ack),
    .o_instruction(o_instruction),
    .o_fault      (o_fault),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_adr     (o_wb_adr),
    .i_wb_dat     (i_wb_dat),
    .i_wb_ack     (i_wb_ack),
    .i_wb_err     (i_wb_err),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [13:0] w);
    if (w == 14'h041) return 32'h00A0_0093;
    return {w, 2'b00, w[7:0], 8'h13} ^ 32'h5A00_0000;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Wishbone slave: mode 0 = ack, 1 = err with ack, 2 = silent
  int slave_lat  = 1;
  int slave_mode = 0;
  bit slave_en   = 1'b1;
  int wait_cnt   = 0;

  initial forever begin
    @(posedge i_clk);
    #1;
    if (slave_en) begin
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      if (o_wb_cyc && slave_mode != 2) begin
        wait_cnt++;
        if (wait_cnt == slave_lat + 1) begin
          i_wb_ack = 1'b1;
          i_wb_err = (slave_mode == 1);
          i_wb_dat = (slave_mode == 1) ? 32'hDEAD_BEEF : mem_word(o_wb_adr);
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard: one expected {data, fault} per o_ack, checked the following cycle
  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t          sb[$];
  exp_t          e_mon;
  int            acks      = 0;
  int            starts    = 0;
  int            run_len   = 0;
  logic [13:0]   start_adr = '0;
  logic          ack_prev  = 1'b0;
  logic          cyc_prev  = 1'b0;

  initial forever begin
    @(negedge i_clk);
    if (ack_prev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got o_instruction 0x%08h with nothing expected", o_instruction);
      end else begin
        e_mon = sb.pop_front();
        chk("sb_instruction", o_instruction, e_mon.data);
        chk("sb_fault", 32'(o_fault), 32'(e_mon.fault));
      end
    end
    ack_prev = o_ack;
    if (o_ack) acks++;
    if (o_wb_cyc && !cyc_prev) begin
      starts++;
      start_adr = o_wb_adr;
      run_len   = 0;
      chk("stb_eq_cyc", 32'(o_wb_stb), 32'(o_wb_cyc));
    end
    if (o_wb_cyc) run_len++;
    cyc_prev = o_wb_cyc;
  end

  task automatic wait_ack(input string name, output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge i_clk);
      n++;
      got = o_ack;
      step();
    end
    i_cyc = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no o_ack within %0d cycles", name, n);
      if (sb.size() > 0) void'(sb.pop_back());
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    int          lat;
    int          mode;
    bit          miss;
    logic [31:0] data;
    bit          fault;
    int          cyc;
    int          run;
  } vec_t;

  task automatic run_vec(input string name, input vec_t v);
    int   s0;
    int   n;
    bit   got;
    exp_t e;
    s0         = starts;
    slave_lat  = v.lat;
    slave_mode = v.mode;
    e.data     = v.data;
    e.fault    = v.fault;
    sb.push_back(e);
    i_addr = v.addr;
    i_cyc  = 1'b1;
    wait_ack(name, n, got);
    if (got) begin
      chk({name, "_latency"}, 32'(n), 32'(v.cyc));
      chk({name, "_bus_reads"}, 32'(starts - s0), 32'(v.miss));
      if (v.miss) chk({name, "_wb_adr"}, 32'(start_adr), 32'(v.addr[15:2]));
      if (v.run != 0) chk({name, "_cyc_len"}, 32'(run_len), 32'(v.run));
      chk({name, "_busy_after"}, 32'(o_busy), 32'd0);
    end
  endtask

  vec_t vt[11];

  initial begin
    int s0;
    int a0;
    int n;
    bit got;
    exp_t e;

    vt[0]  = '{16'h0104, 2, 0, 1'b1, 32'h00A0_0093,    1'b0, 5, 3};
    vt[1]  = '{16'h0106, 0, 0, 1'b0, 32'h00A0_0093,    1'b0, 1, 0};
    vt[2]  = '{16'h0104, 0, 0, 1'b0, 32'h00A0_0093,    1'b0, 1, 0};
    vt[3]  = '{16'h0108, 1, 0, 1'b1, mem_word(14'h042), 1'b0, 4, 2};
    vt[4]  = '{16'h0200, 0, 0, 1'b1, mem_word(14'h080), 1'b0, 3, 1};
    vt[5]  = '{16'h0300, 3, 0, 1'b1, mem_word(14'h0C0), 1'b0, 6, 4};
    vt[6]  = '{16'h0400, 1, 1, 1'b1, 32'h0000_0000,    1'b1, 4, 2};
    vt[7]  = '{16'h0402, 0, 0, 1'b0, 32'h0000_0000,    1'b1, 1, 0};
    vt[8]  = '{16'h0500, 0, 2, 1'b1, 32'h0000_0000,    1'b1, 6, 4};
    vt[9]  = '{16'h0501, 0, 0, 1'b0, 32'h0000_0000,    1'b1, 1, 0};
    vt[10] = '{16'h0108, 2, 0, 1'b1, mem_word(14'h042), 1'b0, 5, 3};

    // Reset state, with a request already presented
    #2 i_reset_n = 1'b0;
    i_cyc  = 1'b1;
    i_addr = 16'h0104;
    #10;
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_wb_cyc", 32'(o_wb_cyc), 32'd0);
    chk("rst_wb_stb", 32'(o_wb_stb), 32'd0);
    chk("rst_wb_adr", 32'(o_wb_adr), 32'd0);
    chk("rst_instruction", o_instruction, 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    i_cyc = 1'b0;
    step();
    i_reset_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i]);
    end

    // Invalidate in IDLE: no ack, no bus request, next fetch misses
    i_cyc  = 1'b1;
    i_addr = 16'h0108;
    i_inv  = 1'b1;
    @(negedge i_clk);
    chk("inv_idle_ack", 32'(o_ack), 32'd0);
    step();
    i_inv = 1'b0;
    i_cyc = 1'b0;
    chk("inv_idle_no_req", 32'(o_wb_cyc), 32'd0);
    run_vec("inv_idle_refetch", '{16'h0108, 0, 0, 1'b1, mem_word(14'h042), 1'b0, 3, 1});

    // Invalidate during REQ: fill discarded, same word re-read
    s0 = starts;
    a0 = acks;
    slave_lat  = 2;
    slave_mode = 0;
    e.data  = mem_word(14'h180);
    e.fault = 1'b0;
    sb.push_back(e);
    i_cyc  = 1'b1;
    i_addr = 16'h0600;
    step();
    @(negedge i_clk);
    chk("inv_req_busy", 32'(o_busy), 32'd1);
    step();
    i_inv = 1'b1;
    step();
    i_inv = 1'b0;
    wait_ack("inv_req", n, got);
    chk("inv_req_bus_reads", 32'(starts - s0), 32'd2);
    chk("inv_req_wb_adr", 32'(start_adr), 32'h180);
    chk("inv_req_acks", 32'(acks - a0), 32'd1);

    // Address moves during REQ: bus address holds, stale fill is never acked
    s0 = starts;
    a0 = acks;
    e.data  = mem_word(14'h1C1);
    e.fault = 1'b0;
    sb.push_back(e);
    i_cyc  = 1'b1;
    i_addr = 16'h0700;
    step();
    i_addr = 16'h0704;
    @(negedge i_clk);
    chk("stale_wb_adr_hold", 32'(o_wb_adr), 32'h1C0);
    wait_ack("stale", n, got);
    chk("stale_bus_reads", 32'(starts - s0), 32'd2);
    chk("stale_wb_adr", 32'(start_adr), 32'h1C1);
    chk("stale_acks", 32'(acks - a0), 32'd1);

    // Reset in the middle of REQ, then a stray slave ack
    slave_en = 1'b0;
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    i_cyc    = 1'b1;
    i_addr   = 16'h0800;
    step();
    @(negedge i_clk);
    chk("midrst_busy_before", 32'(o_busy), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("midrst_wb_cyc", 32'(o_wb_cyc), 32'd0);
    chk("midrst_wb_stb", 32'(o_wb_stb), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    i_cyc = 1'b0;
    step();
    step();
    i_reset_n = 1'b1;
    step();
    i_wb_ack = 1'b1;
    i_wb_dat = 32'h1234_5678;
    @(negedge i_clk);
    chk("stray_ack_no_ack", 32'(o_ack), 32'd0);
    step();
    i_wb_ack = 1'b0;
    @(negedge i_clk);
    chk("stray_ack_wb_cyc", 32'(o_wb_cyc), 32'd0);
    chk("stray_ack_busy", 32'(o_busy), 32'd0);
    chk("stray_ack_instruction", o_instruction, 32'd0);
    step();
    slave_en = 1'b1;
    run_vec("post_reset", '{16'h0800, 1, 0, 1'b1, mem_word(14'h200), 1'b0, 4, 2});

    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
